// File: rtl/cdma_despreader.sv
// Purpose: despreads a serial CDMA chip stream against a locally regenerated PN
//          sequence and recovers one data bit per CHIPS_PER_BIT chips.
// Latency: bit_out/corr/bit_valid are registered one cycle after the edge that
//          accepts the last chip of a bit.
// Backpressure: none. A chip is taken whenever chip_valid is high, and chip gaps
//          may be any length.
// Build option: define CDMA_RX_LOCK_EN to include the lock detector. Without it,
//          locked is tied low.

module cdma_despreader #(
   parameter int                LFSR_W        = 5,
   parameter logic [LFSR_W-1:0] TAPS          = 5'b10100,
   parameter int                CHIPS_PER_BIT = 31,
   parameter int                LOCK_THR      = 24,
   parameter int                LOCK_BITS     = 3,
   localparam int               CW            = $clog2(CHIPS_PER_BIT + 1) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,       // active-high synchronous reset
   input  logic [LFSR_W-1:0]    seed,
   input  logic                 load,
   input  logic                 chip_in,
   input  logic                 chip_valid,
   output logic                 bit_out,
   output logic                 bit_valid,
   output logic signed [CW-1:0] corr,
   output logic                 locked
);

   localparam int                     CNT_W     = $clog2(CHIPS_PER_BIT);
   localparam logic [CNT_W-1:0]       LAST_CHIP = CNT_W'(CHIPS_PER_BIT - 1);
   localparam logic signed [CW-1:0]   ONE       = CW'(1);

   // Elaboration-time sanity checks on the configuration.
   if (CHIPS_PER_BIT < 2 || CHIPS_PER_BIT > 255) begin : g_bad_cpb
      $error("cdma_despreader: CHIPS_PER_BIT must be within 2..255");
   end
   if (LOCK_BITS < 1 || LOCK_THR < 1 || LOCK_THR > CHIPS_PER_BIT) begin : g_bad_lock
      $error("cdma_despreader: LOCK_BITS >= 1 and 1 <= LOCK_THR <= CHIPS_PER_BIT required");
   end

   logic [LFSR_W-1:0]     pn_state;
   logic [LFSR_W-1:0]     pn_next;
   logic [LFSR_W-1:0]     seed_guarded;
   logic                  pn_chip;
   logic                  chip_match;
   logic signed [CW-1:0]  acc;
   logic signed [CW-1:0]  acc_next;
   logic                  acc_pos;
   logic [CNT_W-1:0]      chip_cnt;
   logic                  last_chip;
   logic                  take_chip;
   logic                  decide;

   // PN step, seed lockup guard, per-chip correlation step and bit-boundary detect.
   always_comb begin
      pn_next      = {pn_state[LFSR_W-2:0], ^(pn_state & TAPS)};
      seed_guarded = (seed == '0) ? '1 : seed;
      pn_chip      = pn_state[LFSR_W-1];
      // A received chip that differs from the PN chip carries data 1.
      chip_match   = chip_in ^ pn_chip;
      acc_next     = chip_match ? (acc + ONE) : (acc - ONE);
      // A strictly positive sum decides 1. A zero tie decides 0.
      acc_pos      = !acc_next[CW-1] && (acc_next != '0);
      last_chip    = (chip_cnt == LAST_CHIP);
      // load takes priority: a chip presented together with load is discarded.
      take_chip    = chip_valid && !load;
      decide       = take_chip && last_chip;
   end

   // PN generator. It reloads on load and otherwise steps once per accepted chip.
   // It is never reseeded at bit boundaries.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         pn_state <= '1;
      end else if (load) begin
         pn_state <= seed_guarded;
      end else if (take_chip) begin
         pn_state <= pn_next;
      end
   end

   // Correlation accumulator and chip-in-bit counter. Both clear at each bit boundary.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         acc      <= '0;
         chip_cnt <= '0;
      end else if (load) begin
         acc      <= '0;
         chip_cnt <= '0;
      end else if (take_chip) begin
         if (last_chip) begin
            acc      <= '0;
            chip_cnt <= '0;
         end else begin
            acc      <= acc_next;
            chip_cnt <= chip_cnt + CNT_W'(1);
         end
      end
   end

   // Decision registers. bit_out and corr hold their values between decisions.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         corr      <= '0;
      end else begin
         bit_valid <= decide;
         if (decide) begin
            bit_out <= acc_pos;
            corr    <= acc_next;
         end
      end
   end

`ifdef CDMA_RX_LOCK_EN
   localparam int LKW = $clog2(LOCK_BITS + 1);

   logic [CW-1:0]  acc_mag;
   logic           good_bit;
   logic [LKW-1:0] good_cnt;
   logic [LKW-1:0] good_cnt_next;

   // Magnitude of the final sum, and the saturating count of consecutive good bits.
   always_comb begin
      acc_mag       = acc_next[CW-1] ? CW'(-acc_next) : CW'(acc_next);
      good_bit      = ({1'b0, acc_mag} >= (CW+1)'(LOCK_THR));
      good_cnt_next = '0;
      if (good_bit) begin
         good_cnt_next = (good_cnt == LKW'(LOCK_BITS)) ? good_cnt : good_cnt + LKW'(1);
      end
   end

   // Lock state updates only at a decision, on the same edge that raises bit_valid.
   always_ff @(posedge clk) begin
      if (rst_n || load) begin
         good_cnt <= '0;
         locked   <= 1'b0;
      end else if (decide) begin
         good_cnt <= good_cnt_next;
         locked   <= (good_cnt_next == LKW'(LOCK_BITS));
      end
   end
`else
   // The lock detector is not built. The port is kept so the interface stays fixed.
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_cdma_despreader.sv
// Purpose: randomized scoreboard bench for cdma_despreader.
// Latency: expects each decision one cycle after the final chip of the bit is accepted.
// Backpressure: the DUT has none. Stimulus inserts chip gaps to exercise idle cycles.

module tb_cdma_despreader;

   localparam int         N         = 31;      // chips per bit
   localparam int         PERIOD    = 31;      // PN period for x^5+x^3+1
   localparam int         LOCK_THR  = 24;
   localparam int         LOCK_BITS = 3;
   localparam logic [4:0] TAPS      = 5'b10100;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [4:0]        seed;
   logic              load;
   logic              chip_in;
   logic              chip_valid;
   logic              bit_out;
   logic              bit_valid;
   logic signed [5:0] corr;
   logic              locked;

   always #5 clk = ~clk;

   cdma_despreader #(
      .LFSR_W(5), .TAPS(TAPS), .CHIPS_PER_BIT(N), .LOCK_THR(LOCK_THR), .LOCK_BITS(LOCK_BITS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .seed(seed), .load(load), .chip_in(chip_in),
      .chip_valid(chip_valid), .bit_out(bit_out), .bit_valid(bit_valid),
      .corr(corr), .locked(locked)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit  b;
      int  c;
      bit  lk;
      time t;
   } exp_t;

   exp_t       exp_q[$];
   logic [30:0] rx_tbl, tx_tbl;   // one full PN period, starting at the loaded seed
   int          rx_pos, tx_pos;
   int          m_cnt, m_sum, lk_cnt;
   time         last_t;

   // One full PN period as a bit table. An all-zero seed behaves like all ones.
   function automatic logic [30:0] pn_table(input logic [4:0] s);
      logic [4:0]  st;
      logic [30:0] tbl;
      st = (s == 5'd0) ? 5'b11111 : s;
      for (int i = 0; i < PERIOD; i++) begin
         tbl[i] = st[4];
         st     = {st[3:0], ^(st & TAPS)};
      end
      return tbl;
   endfunction

   task automatic set_seeds(input logic [4:0] rs, input logic [4:0] ts);
      rx_tbl = pn_table(rs);
      tx_tbl = pn_table(ts);
      rx_pos = 0;
      tx_pos = 0;
      m_cnt  = 0;
      m_sum  = 0;
      lk_cnt = 0;
   endtask

   // Account for one accepted chip. A complete bit pushes its expected decision.
   task automatic model_chip(input bit c, input time t);
      exp_t e;
      int   mag;
      m_sum += (c ^ rx_tbl[rx_pos]) ? 1 : -1;
      rx_pos = (rx_pos + 1) % PERIOD;
      m_cnt++;
      if (m_cnt == N) begin
         mag = (m_sum < 0) ? -m_sum : m_sum;
`ifdef CDMA_RX_LOCK_EN
         lk_cnt = (mag >= LOCK_THR) ? ((lk_cnt < LOCK_BITS) ? lk_cnt + 1 : LOCK_BITS) : 0;
         e.lk   = (lk_cnt == LOCK_BITS);
`else
         e.lk   = (mag < 0);   // no lock logic: always 0
`endif
         e.b   = (m_sum > 0);
         e.c   = m_sum;
         e.t   = t;
         exp_q.push_back(e);
         m_cnt = 0;
         m_sum = 0;
      end
   endtask

   // ---------------- monitor ----------------
   exp_t e_mon;
   bit   last_b;
   int   last_c;

   // Sample on the falling edge. Pop one expectation per pulse and check hold otherwise.
   always @(negedge clk) begin
      if (rst_n) begin
         last_b = 1'b0;
         last_c = 0;
      end else if (bit_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_bit_valid", 1, 0);
         end else begin
            e_mon = exp_q.pop_front();
            check("bit_out", int'(bit_out), int'(e_mon.b));
            check("corr", int'(corr), e_mon.c);
            check("locked", int'(locked), int'(e_mon.lk));
            check("pulse_delay_ns", int'($time - e_mon.t), 5);
         end
         last_b = bit_out;
         last_c = int'(corr);
      end else begin
         check("hold_bit_out", int'(bit_out), int'(last_b));
         check("hold_corr", int'(corr), last_c);
      end
   end

   // ---------------- stimulus ----------------
   task automatic accept_chip(input bit c);
      chip_in    = c;
      chip_valid = 1'b1;
      @(posedge clk);
      last_t     = $time;
      model_chip(c, last_t);
      #1 chip_valid = 1'b0;
   endtask

   task automatic send_chips(input bit d, input int count, input int nflip, input int gap);
      bit c;
      for (int i = 0; i < count; i++) begin
         c      = d ^ tx_tbl[tx_pos] ^ (i < nflip);
         tx_pos = (tx_pos + 1) % PERIOD;
         accept_chip(c);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic send_bit(input bit d, input int nflip, input int gap);
      send_chips(d, N, nflip, gap);
   endtask

   task automatic do_load(input logic [4:0] rs, input logic [4:0] ts, input bit with_chip);
      seed       = rs;
      load       = 1'b1;
      chip_valid = with_chip;
      chip_in    = 1'($urandom);
      @(posedge clk);
      #1;
      load       = 1'b0;
      chip_valid = 1'b0;
      set_seeds(rs, ts);
      @(negedge clk);
      check("locked_after_load", int'(locked), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit with_load);
      rst_n      = 1'b1;
      load       = with_load;
      chip_valid = with_load;
      seed       = 5'b00110;
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      load       = 1'b0;
      chip_valid = 1'b0;
      set_seeds(5'b11111, 5'b11111);
      @(negedge clk);
      check("rst_bit_out", int'(bit_out), 0);
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_corr", int'(corr), 0);
      check("rst_locked", int'(locked), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; load = 1'b0; chip_in = 1'b0; chip_valid = 1'b0; seed = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      do_reset(1'b0);

      // clean bits, one chip per clock
      do_load(5'b01101, 5'b01101, 1'b0);
      send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0);

      // five inverted chips in the first bit
      do_load(5'b01101, 5'b01101, 1'b0);
      send_bit(1, 5, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0);

      // chip_valid one cycle in three
      do_load(5'b01101, 5'b01101, 1'b0);
      send_bit(1, 0, 2); send_bit(0, 0, 2); send_bit(1, 0, 2); send_bit(1, 0, 2);

      // lock build-up, then receive-seed mismatch
      do_load(5'b01101, 5'b01101, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0, 0);
      do_load(5'b00001, 5'b01101, 1'b0);
      send_bit(1, 0, 0); send_bit(0, 0, 0);

      // load after chip 10 of a bit, with a chip presented on the load cycle
      do_load(5'b01101, 5'b01101, 1'b0);
      send_bit(1, 0, 0);
      send_chips(0, 10, 0, 0);
      do_load(5'b01101, 5'b01101, 1'b1);
      send_bit(0, 0, 0); send_bit(1, 0, 0);

      // reset mid-bit, then decode from the reset state without a load
      send_chips(1, 12, 0, 0);
      do_reset(1'b0);
      send_bit(1, 0, 0); send_bit(0, 0, 1);

      // reset while load and chip_valid are both high
      send_chips(0, 7, 0, 0);
      do_reset(1'b1);
      send_bit(1, 3, 0);

      // all-zero seed decodes like all ones
      do_load(5'b00000, 5'b11111, 1'b0);
      send_bit(0, 0, 0); send_bit(1, 0, 0);

      // randomized seeds, data, corruption and gaps
      for (int k = 0; k < 6; k++) begin
         logic [4:0] s;
         s = 5'($urandom);
         do_load(s, s, 1'($urandom));
         for (int j = 0; j < 3; j++)
            send_bit(1'($urandom), $urandom_range(0, 12), $urandom_range(0, 2));
      end

      repeat (5) @(posedge clk);
      check("pending_decisions", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cdma_despreader.md
# cdma_despreader

Receive-side despreader for the CDMA chain. Consumes the serial chip stream produced by the spreader (data XOR PN chip), regenerates the identical PN sequence from the same seed, and correlates each bit period. Emits one recovered data bit per `CHIPS_PER_BIT` accepted chips, together with the signed correlation value. Sits directly downstream of the spreader's chip output inside the CDMA top level.

## Interface

Parameters:
- `LFSR_W`, 5: PN generator width; matches the spreader seed width.
- `TAPS`, 5'b10100: feedback tap mask (x^5+x^3+1, maximal length, period 31).
- `CHIPS_PER_BIT`, 31: spreading factor; legal range 2..255.
- `LOCK_THR`, 24: minimum |correlation| counted as a good bit (lock feature only).
- `LOCK_BITS`, 3: consecutive good bits required to assert `locked` (lock feature only).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-high reset (name kept for codebase consistency; asserted = 1).
- `seed` in `LFSR_W`: PN seed, same value loaded into the spreader.
- `load` in 1: level; loads `seed` and realigns the bit boundary.
- `chip_in` in 1: received chip.
- `chip_valid` in 1: `chip_in` is accepted on this edge.
- `bit_out` out 1: last recovered data bit, held until the next decision.
- `bit_valid` out 1: one-cycle pulse when `bit_out`/`corr` update.
- `corr` out CW: signed correlation of the last bit, CW = clog2(CHIPS_PER_BIT+1)+1 (6 for default).
- `locked` out 1: lock indicator (see Configuration).

## Operation

- PN generator: Fibonacci LFSR; fb = XOR(state & TAPS); next = {state[LFSR_W-2:0], fb}; PN chip = state[LFSR_W-1]. Identical to the spreader LFSR.
- All-zero seed is replaced by all-ones on load (lockup guard).
- On each accepted chip: d = chip_in XOR pn; acc += d ? +1 : -1; LFSR advances; chip counter increments.
- When the chip counter reaches `CHIPS_PER_BIT`-1 with a chip accepted: decision uses acc including that chip; `bit_out` = (final acc > 0), tie (even factor only) -> 0; `corr` = final acc; `bit_valid` = 1; acc and counter clear. LFSR continues free (no reseed per bit).
- `load` = 1: state <= seed (guarded), acc <= 0, counter <= 0, no decision; held load keeps reloading. `load` and `chip_valid` together: load wins, chip discarded.
- `chip_valid` = 0: nothing advances; gaps of any length allowed.
- Reset: state all-ones, acc 0, counter 0, `bit_out` 0, `bit_valid` 0, `corr` 0, `locked` 0. Reset wins over `load` and `chip_valid`. Reset mid-bit discards the partial bit.
- Arithmetic: acc signed CW bits; range ±`CHIPS_PER_BIT`, never overflows.

## Timing

- All outputs registered.
- `bit_valid` asserted in the cycle after the edge that accepted the final chip of a bit; exactly one cycle wide; back-to-back bits at one chip/clock give one pulse every `CHIPS_PER_BIT` cycles.
- `bit_out`, `corr` change only with `bit_valid`; stable otherwise.
- First chip after `load` deasserts is correlated against PN chip = seed[LFSR_W-1], aligning with a spreader loaded on the same edge.
- `locked` updates on the same edge as `bit_valid`.

## Configuration

- `CDMA_RX_LOCK_EN` defined: lock detector compiled in. Good-bit counter increments (saturating at `LOCK_BITS`) when |final acc| >= `LOCK_THR`, else clears; `locked` = 1 while counter == `LOCK_BITS`. Cleared by reset and `load`.
- Undefined: no lock logic synthesized; `locked` tied 0; port kept for a fixed interface.

## Test plan

- Reset, seed 5'b01101, load 1 cycle, feed bits 1,0,1,1 spread with reference LFSR at one chip/clock -> `bit_out` 1,0,1,1; `corr` +31,-31,+31,+31; `bit_valid` pulses 31 cycles apart, first one cycle after chip 31.
- Same stream with 5 chips of the first bit inverted -> `corr` = +21, `bit_out` 1.
- Lock enabled, 4 clean bits -> `locked` rises with 3rd `bit_valid`; then seed mismatch (rx 5'b00001, tx 5'b01101) -> |corr| < 24, `locked` drops on the next decision.
- `chip_valid` toggled 1-of-3 cycles -> identical `bit_out`/`corr` sequence as scenario 1, pulses spaced 93 cycles.
- `load` asserted after chip 10 of a bit, with `chip_valid` high that cycle -> no `bit_valid` for partial bit, chip discarded, next 31 chips decode correctly from the seed.
- Reset asserted mid-bit and during `load` -> all outputs 0 next cycle; seed 5'b00000 load -> PN equals sequence from all-ones.
